// File: rtl/tile_compute_engine.sv
// Tile compute engine: streams A/B operands out of SRAM and writes saturated
// MUL/ADD/SUB/DOT results element by element, in row-major order.
//
//  state | meaning
//  IDLE  | waiting for start; op and bases latched on acceptance
//  READ  | one A/B read pair per cycle, k = 0..L-1
//  DRAIN | accumulate the data returned for the last read
//  WRITE | write sat(acc) to C, then advance to the next element or finish
//  FIN   | done pulse with the sticky saturation flag
module tile_compute_engine #(
    parameter int DW    = 8,
    parameter int N     = 4,
    parameter int K     = 16,
    parameter int AW    = 10,
    parameter int ACC_W = 2*DW + $clog2(K) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op_code,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    input  logic [AW-1:0] base_c,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    input  logic [DW-1:0] a_dout,
    input  logic [DW-1:0] b_dout,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [DW-1:0] c_din,
    output logic          busy,
    output logic          done,
    output logic          sat
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_DOT = 2'd3;

    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((2**(DW-1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(2**(DW-1)));

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_FIN
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               op_q, op_d;
    logic [AW-1:0]            base_a_q, base_a_d;
    logic [AW-1:0]            base_b_q, base_b_d;
    logic [AW-1:0]            base_c_q, base_c_d;
    logic [RW-1:0]            r_q, r_d;
    logic [RW-1:0]            c_q, c_d;
    logic [KW-1:0]            k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     sat_acc_q, sat_acc_d;
    logic [AW-1:0]            a_addr_q, a_addr_d;
    logic [AW-1:0]            b_addr_q, b_addr_d;

    // Read address for operand A (is_b=0) or B (is_b=1); sums wrap modulo 2^AW.
    function automatic logic [AW-1:0] rd_addr(
        input logic          is_b,
        input logic [1:0]    op,
        input logic [AW-1:0] base,
        input logic [31:0]   r,
        input logic [31:0]   c,
        input logic [31:0]   k
    );
        logic [31:0] off;
        case (op)
            OP_MUL:  off = is_b ? (k * N + c) : (r * K + k);
            OP_DOT:  off = k;
            default: off = r * N + c;
        endcase
        return base + off[AW-1:0];
    endfunction

    logic signed [DW-1:0]    a_s, b_s;
    logic signed [2*DW-1:0]  prod;
    logic signed [DW:0]      sum_ab, dif_ab;
    logic signed [ACC_W-1:0] step_val;
    logic                    sat_hi, sat_lo;
    logic [KW-1:0]           last_k;
    logic                    last_elem;
    logic [RW-1:0]           r_n, c_n;

    assign a_s    = a_dout;
    assign b_s    = b_dout;
    assign prod   = (2*DW)'(a_s) * (2*DW)'(b_s);
    assign sum_ab = (DW+1)'(a_s) + (DW+1)'(b_s);
    assign dif_ab = (DW+1)'(a_s) - (DW+1)'(b_s);

    always_comb begin
        case (op_q)
            OP_ADD:  step_val = ACC_W'(sum_ab);
            OP_SUB:  step_val = ACC_W'(dif_ab);
            default: step_val = acc_q + ACC_W'(prod);
        endcase
    end

    assign sat_hi    = (acc_q > SMAX);
    assign sat_lo    = (acc_q < SMIN);
    assign last_k    = (op_q == OP_MUL || op_q == OP_DOT) ? KW'(K - 1) : '0;
    assign last_elem = (op_q == OP_DOT) || (r_q == RW'(N - 1) && c_q == RW'(N - 1));
    assign c_n       = (c_q == RW'(N - 1)) ? '0 : c_q + 1'b1;
    assign r_n       = (c_q == RW'(N - 1)) ? r_q + 1'b1 : r_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        base_a_d  = base_a_q;
        base_b_d  = base_b_q;
        base_c_d  = base_c_q;
        r_d       = r_q;
        c_d       = c_q;
        k_d       = k_q;
        acc_d     = acc_q;
        sat_acc_d = sat_acc_q;
        a_addr_d  = a_addr_q;
        b_addr_d  = b_addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op_code;
                    base_a_d  = base_a;
                    base_b_d  = base_b;
                    base_c_d  = base_c;
                    r_d       = '0;
                    c_d       = '0;
                    k_d       = '0;
                    sat_acc_d = 1'b0;
                    a_addr_d  = rd_addr(1'b0, op_code, base_a, 32'd0, 32'd0, 32'd0);
                    b_addr_d  = rd_addr(1'b1, op_code, base_b, 32'd0, 32'd0, 32'd0);
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                // Data on a_dout/b_dout now belongs to read k-1 (stale at k=0).
                acc_d = (k_q == '0) ? '0 : step_val;
                if (k_q == last_k) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d      = k_q + 1'b1;
                    a_addr_d = rd_addr(1'b0, op_q, base_a_q, 32'(r_q), 32'(c_q), 32'(k_q) + 32'd1);
                    b_addr_d = rd_addr(1'b1, op_q, base_b_q, 32'(r_q), 32'(c_q), 32'(k_q) + 32'd1);
                end
            end
            S_DRAIN: begin
                acc_d   = step_val;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                sat_acc_d = sat_acc_q | sat_hi | sat_lo;
                if (last_elem) begin
                    state_d = S_FIN;
                end else begin
                    r_d      = r_n;
                    c_d      = c_n;
                    k_d      = '0;
                    a_addr_d = rd_addr(1'b0, op_q, base_a_q, 32'(r_n), 32'(c_n), 32'd0);
                    b_addr_d = rd_addr(1'b1, op_q, base_b_q, 32'(r_n), 32'(c_n), 32'd0);
                    state_d  = S_READ;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            base_a_q  <= '0;
            base_b_q  <= '0;
            base_c_q  <= '0;
            r_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            sat_acc_q <= 1'b0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            base_a_q  <= base_a_d;
            base_b_q  <= base_b_d;
            base_c_q  <= base_c_d;
            r_q       <= r_d;
            c_q       <= c_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            sat_acc_q <= sat_acc_d;
            a_addr_q  <= a_addr_d;
            b_addr_q  <= b_addr_d;
        end
    end

    assign a_addr = a_addr_q;
    assign b_addr = b_addr_q;
    assign busy   = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_WRITE);
    assign done   = (state_q == S_FIN);
    assign sat    = (state_q == S_FIN) && sat_acc_q;
    assign c_we   = (state_q == S_WRITE);
    assign c_addr = (op_q == OP_DOT) ? base_c_q
                                     : base_c_q + AW'(32'(r_q) * N + 32'(c_q));
    assign c_din  = sat_hi ? {1'b0, {(DW-1){1'b1}}} :
                    sat_lo ? {1'b1, {(DW-1){1'b0}}} : acc_q[DW-1:0];

endmodule

// File: tb/tb_tile_compute_engine.sv
// Scoreboard bench for tile_compute_engine: directed operations push expected
// writes/done events; a negedge monitor pops and compares them.
module tb_tile_compute_engine;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int K  = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op_code = '0;
    logic [AW-1:0] base_a = '0, base_b = '0, base_c = '0;
    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic [DW-1:0] a_dout = '0, b_dout = '0;
    logic          c_we, busy, done, sat;
    logic [DW-1:0] c_din;

    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] mem_b [0:(1<<AW)-1];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic sat;
        int   start_cyc;
        int   lat;
    } dn_t;

    wr_t exp_w[$];
    dn_t exp_d[$];
    int  checks = 0;
    int  failures = 0;
    int  n_wr = 0;
    int  cyc = 0;

    tile_compute_engine #(.DW(DW), .N(N), .K(K), .AW(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_code(op_code),
        .base_a (base_a),
        .base_b (base_b),
        .base_c (base_c),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .a_dout (a_dout),
        .b_dout (b_dout),
        .c_we   (c_we),
        .c_addr (c_addr),
        .c_din  (c_din),
        .busy   (busy),
        .done   (done),
        .sat    (sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        a_dout <= mem_a[a_addr];
        b_dout <= mem_b[b_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (c_we) begin
            n_wr++;
            chk("write_expected", int'(exp_w.size() > 0), 1);
            if (exp_w.size() > 0) begin
                w = exp_w.pop_front();
                chk("wr_addr", c_addr, w.addr);
                chk("wr_data", c_din, w.data);
            end
        end
        if (done) begin
            chk("done_expected", int'(exp_d.size() > 0), 1);
            if (exp_d.size() > 0) begin
                d = exp_d.pop_front();
                chk("done_sat", sat, d.sat);
                chk("done_latency", cyc - d.start_cyc, d.lat);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic push_w(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_w.push_back(w);
    endtask

    task automatic start_op(input logic [1:0] op, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                            input logic [AW-1:0] bc, input int lat, input logic sat_e, input bit exp_done);
        dn_t d;
        @(negedge clk);
        op_code = op;
        base_a  = ba;
        base_b  = bb;
        base_c  = bc;
        start   = 1'b1;
        if (exp_done) begin
            d.sat       = sat_e;
            d.start_cyc = cyc;
            d.lat       = lat;
            exp_d.push_back(d);
        end
        @(negedge clk);
        start   = 1'b0;
        op_code = ~op;
        base_a  = ~ba;
        base_b  = ~bb;
        base_c  = ~bc;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nw0;
        int n;
        logic [AW-1:0] ea;
        for (int i = 0; i < (1<<AW); i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end

        // Reset values while rst_n is held low
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat, 0);
        chk("rst_c_we", c_we, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_b_addr", b_addr, 0);
        chk("rst_c_addr", c_addr, 0);
        chk("rst_c_din", c_din, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // MUL, A = 1, B = 2: every element 16*2 = 32
        for (int i = 0; i < N*K; i++) begin
            mem_a[i]         = 8'd1;
            mem_b[10'h100+i] = 8'd2;
        end
        for (int i = 0; i < N*N; i++) push_w(10'h200 + 10'(i), 8'h20);
        start_op(2'd0, 10'h000, 10'h100, 10'h200, 289, 1'b0, 1'b1);
        wait_done(400);

        // MUL, A = identity in columns 0..3, B[k][c] = 4k+c: C[r][c] = 4r+c
        for (int r = 0; r < N; r++)
            for (int k = 0; k < K; k++)
                mem_a[10'h040 + 10'(r*K + k)] = (k == r) ? 8'd1 : 8'd0;
        for (int k = 0; k < K; k++)
            for (int c = 0; c < N; c++)
                mem_b[10'h140 + 10'(k*N + c)] = (k < 4) ? 8'(4*k + c) : 8'd7;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                push_w(10'h210 + 10'(r*N + c), 8'(4*r + c));
        start_op(2'd0, 10'h040, 10'h140, 10'h210, 289, 1'b0, 1'b1);
        wait_done(400);

        // ADD 100+100 clamps to 127; SUB -100-100 clamps to -128
        for (int i = 0; i < N*N; i++) begin
            mem_a[10'h080+i] = 8'd100;
            mem_b[10'h180+i] = 8'd100;
            mem_a[10'h090+i] = 8'h9C;
            mem_b[10'h190+i] = 8'd100;
            push_w(10'h220 + 10'(i), 8'h7F);
        end
        start_op(2'd1, 10'h080, 10'h180, 10'h220, 49, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        start   = 1'b1;
        op_code = 2'd3;
        base_a  = 10'h3FE;
        base_b  = 10'h000;
        base_c  = 10'h3FF;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);

        for (int i = 0; i < N*N; i++) push_w(10'h230 + 10'(i), 8'h80);
        start_op(2'd2, 10'h090, 10'h190, 10'h230, 49, 1'b1, 1'b1);
        wait_done(100);

        // DOT a[k]=k, b[k]=1: 0+1+..+15 = 120
        for (int k = 0; k < K; k++) begin
            mem_a[10'h0A0+k] = 8'(k);
            mem_b[10'h1A0+k] = 8'd1;
        end
        push_w(10'h240, 8'd120);
        start_op(2'd3, 10'h0A0, 10'h1A0, 10'h240, 19, 1'b0, 1'b1);
        wait_done(40);

        // DOT across the address wrap, a=-2, b=3: 16*(-6) = -96
        for (int k = 0; k < K; k++) begin
            ea = 10'h3FE + 10'(k);
            mem_a[ea]        = 8'hFE;
            mem_b[10'h1C0+k] = 8'd3;
        end
        push_w(10'h3FF, 8'hA0);
        start_op(2'd3, 10'h3FE, 10'h1C0, 10'h3FF, 19, 1'b0, 1'b1);
        for (int k = 0; k < K; k++) begin
            ea = 10'h3FE + 10'(k);
            chk("dot_wrap_a_addr", a_addr, ea);
            chk("dot_b_addr", b_addr, 10'h1C0 + k);
            if (k < K-1) @(negedge clk);
        end
        wait_done(40);

        // Reset during MUL element 5: writes 0..4 only, no done
        for (int i = 0; i < N*K; i++) begin
            mem_a[i]         = 8'd1;
            mem_b[10'h100+i] = 8'd2;
        end
        for (int i = 0; i < 5; i++) push_w(10'h200 + 10'(i), 8'h20);
        nw0 = n_wr;
        start_op(2'd0, 10'h000, 10'h100, 10'h200, 289, 1'b0, 1'b0);
        n = 0;
        while (n_wr < nw0 + 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("writes_before_abort", n_wr - nw0, 5);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_c_we", c_we, 0);
        chk("abort_a_addr", a_addr, 0);
        repeat (10) begin
            @(negedge clk);
            chk("abort_hold_c_we", c_we, 0);
            chk("abort_hold_done", done, 0);
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("no_resume_busy", busy, 0);
        end

        // Fresh start after the abort
        push_w(10'h240, 8'd120);
        start_op(2'd3, 10'h0A0, 10'h1A0, 10'h240, 19, 1'b0, 1'b1);
        wait_done(40);

        @(negedge clk);
        chk("writes_left", exp_w.size(), 0);
        chk("dones_left", exp_d.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
